// File: rtl/comar_mask_scheduler_if.sv
// rtl/comar_mask_scheduler_if.sv - request/randomness/grant bundle between gadgets, PRNG and mask scheduler
// master: gadget+PRNG side; slave: the scheduler.
interface comar_mask_scheduler_if #(
  parameter int NREQ = 4,
  parameter int RW   = 8
);
  logic [NREQ-1:0] req;
  logic [RW-1:0]   rnd_in;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [NREQ-1:0] gnt;
  logic [RW-1:0]   mask_out;
  logic            mask_valid;

  modport master (
    output req, rnd_in, rnd_valid,
    input  rnd_ready, gnt, mask_out, mask_valid
  );

  modport slave (
    input  req, rnd_in, rnd_valid,
    output rnd_ready, gnt, mask_out, mask_valid
  );
endinterface

// File: rtl/comar_mask_scheduler.sv
// rtl/comar_mask_scheduler.sv - round-robin sharing of one fresh-mask stream among NREQ COMAR gadgets
// Optional mask reuse across grants is enabled by defining COMAR_MASK_REUSE_EN.
module comar_mask_scheduler #(
  parameter int NREQ        = 4,
  parameter int RW          = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int REUSE_MAX   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  comar_mask_scheduler_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [RW-1:0]   mask_q, mask_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [RW-1:0]   mout_q, mout_d;
  logic            mv_q, mv_d;
  logic            rdy_c;

`ifdef COMAR_MASK_REUSE_EN
  // mask_ok guards against reusing the all-zero mask_q left by reset
  logic [3:0]      rc_q, rc_d;
  logic            ok_q, ok_d;
`endif

  logic            any_req;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   scan_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] w);
    logic [NREQ-1:0] r;
    r    = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Scan downward so the closest set bit at or above ptr is assigned last.
  always_comb begin
    any_req  = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = PW'((int'(ptr_q) + i) % NREQ);
      if (bus.req[scan_idx]) begin
        any_req = 1'b1;
        pick    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    mout_d  = mout_q;
    mv_d    = mv_q;
    rdy_c   = 1'b0;
`ifdef COMAR_MASK_REUSE_EN
    rc_d    = rc_q;
    ok_d    = ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = pick;
          state_d = FETCH;
`ifdef COMAR_MASK_REUSE_EN
          if (ok_q && (int'(rc_q) < REUSE_MAX - 1)) begin
            gnt_d   = onehot(pick);
            mout_d  = mask_q;
            mv_d    = 1'b1;
            cnt_d   = 4'(HOLD_CYCLES - 1);
            rc_d    = rc_q + 4'd1;
            state_d = HOLD;
          end
`endif
        end
      end
      FETCH: begin
        rdy_c = bus.req[win_q];
        if (!bus.req[win_q]) begin
          state_d = IDLE;
        end else if (bus.rnd_valid) begin
          mask_d  = bus.rnd_in;
          mout_d  = bus.rnd_in;
          gnt_d   = onehot(win_q);
          mv_d    = 1'b1;
          cnt_d   = 4'(HOLD_CYCLES - 1);
          state_d = HOLD;
`ifdef COMAR_MASK_REUSE_EN
          rc_d    = 4'd0;
          ok_d    = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          gnt_d   = '0;
          mv_d    = 1'b0;
          mout_d  = '0;
          ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
`ifndef COMAR_MASK_REUSE_EN
        mask_d  = '0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      mout_q  <= '0;
      mv_q    <= 1'b0;
`ifdef COMAR_MASK_REUSE_EN
      rc_q    <= '0;
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      mout_q  <= mout_d;
      mv_q    <= mv_d;
`ifdef COMAR_MASK_REUSE_EN
      rc_q    <= rc_d;
      ok_q    <= ok_d;
`endif
    end
  end

  assign bus.rnd_ready  = rdy_c & ~rst;
  assign bus.gnt        = gnt_q;
  assign bus.mask_out   = mout_q;
  assign bus.mask_valid = mv_q;

endmodule

// File: tb/tb_comar_mask_scheduler.sv
// tb/tb_comar_mask_scheduler.sv - directed self-checking bench for comar_mask_scheduler
module tb_comar_mask_scheduler;
  localparam int NREQ = 4;
  localparam int RW   = 8;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comar_mask_scheduler_if #(.NREQ(NREQ), .RW(RW)) bus ();

  comar_mask_scheduler #(
    .NREQ(NREQ), .RW(RW), .HOLD_CYCLES(HOLD), .REUSE_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [NREQ+RW:0] exp_v;
  logic             exp_rdy;

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.gnt, bus.mask_out, bus.mask_valid} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {bus.gnt, bus.mask_out, bus.mask_valid});
    checks++;
    if (bus.rnd_ready !== 1'b0)
      $display("FAIL reset_rnd_ready: got %b expected 0", bus.rnd_ready);
    if (bus.rnd_ready !== 1'b0 || {bus.gnt, bus.mask_out, bus.mask_valid} !== '0) errors++;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req = (c < 3) ? 4'b0001 : 4'b0000;
      bus.rnd_valid = 1'b1;
      bus.rnd_in = 8'hA5;
      #1;
      exp_v = (c == 2 || c == 3) ? {4'b0001, 8'hA5, 1'b1} : '0;
      exp_rdy = (c == 1);
      checks++;
      if ({bus.gnt, bus.mask_out, bus.mask_valid} !== exp_v) begin
        errors++;
        $display("FAIL single_out c%0d: got %h expected %h", c, {bus.gnt, bus.mask_out, bus.mask_valid}, exp_v);
      end
      checks++;
      if (bus.rnd_ready !== exp_rdy) begin
        errors++;
        $display("FAIL single_rdy c%0d: got %b expected %b", c, bus.rnd_ready, exp_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_req();
    int k, ph;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      bus.req = 4'b1111;
      bus.rnd_valid = 1'b1;
      bus.rnd_in = 8'(16 + c);
      #1;
      k  = (c - 2) / 5;
      ph = (c - 2) % 5;
      if (c >= 2 && ph < HOLD && k < 4) exp_v = {4'(1 << k), 8'(17 + 5 * k), 1'b1};
      else exp_v = '0;
      exp_rdy = (c >= 1) && ((c - 1) % 5 == 0);
      checks++;
      if ({bus.gnt, bus.mask_out, bus.mask_valid} !== exp_v) begin
        errors++;
        $display("FAIL all_req_out c%0d: got %h expected %h", c, {bus.gnt, bus.mask_out, bus.mask_valid}, exp_v);
      end
      checks++;
      if (bus.rnd_ready !== exp_rdy) begin
        errors++;
        $display("FAIL all_req_rdy c%0d: got %b expected %b", c, bus.rnd_ready, exp_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_starved();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req = 4'b0100;
      bus.rnd_valid = (c >= 6);
      bus.rnd_in = (c >= 6) ? 8'h3C : 8'hFF;
      #1;
      exp_v = (c == 7 || c == 8) ? {4'b0100, 8'h3C, 1'b1} : '0;
      exp_rdy = (c >= 1 && c <= 6);
      checks++;
      if ({bus.gnt, bus.mask_out, bus.mask_valid} !== exp_v) begin
        errors++;
        $display("FAIL starved_out c%0d: got %h expected %h", c, {bus.gnt, bus.mask_out, bus.mask_valid}, exp_v);
      end
      checks++;
      if (bus.rnd_ready !== exp_rdy) begin
        errors++;
        $display("FAIL starved_rdy c%0d: got %b expected %b", c, bus.rnd_ready, exp_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    bus.req = 4'b0010;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rnd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_fetch_rdy: got %b expected 1", bus.rnd_ready);
    end
    bus.req = 4'b0000;
    #1;
    checks++;
    if (bus.rnd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop_rdy: got %b expected 0", bus.rnd_ready);
    end
    @(negedge clk);
    // ptr must still be 0: req 1001 must pick gadget 0, not gadget 3
    bus.req = 4'b1001;
    bus.rnd_valid = 1'b1;
    bus.rnd_in = 8'h77;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt, bus.mask_out, bus.mask_valid} !== {4'b0001, 8'h77, 1'b1}) begin
      errors++;
      $display("FAIL abort_ptr_grant: got %h expected %h", {bus.gnt, bus.mask_out, bus.mask_valid}, {4'b0001, 8'h77, 1'b1});
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt, bus.mask_out, bus.mask_valid} !== '0) begin
      errors++;
      $display("FAIL hold_reset_out: got %h expected 0", {bus.gnt, bus.mask_out, bus.mask_valid});
    end
    do_reset();
    bus.req = 4'b0001;
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rnd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rst_rdy: got %b expected 0", bus.rnd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef COMAR_MASK_REUSE_EN
  task automatic test_reuse();
    int pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.req = 4'b0011;
      bus.rnd_valid = 1'b1;
      bus.rnd_in = (c < 2) ? 8'h5A : 8'hC3;
      #1;
      if (bus.rnd_ready === 1'b1) pulses++;
      if (c == 2 || c == 3) exp_v = {4'b0001, 8'h5A, 1'b1};
      else if (c == 6 || c == 7) exp_v = {4'b0010, 8'h5A, 1'b1};
      else if (c == 11 || c == 12) exp_v = {4'b0001, 8'hC3, 1'b1};
      else exp_v = '0;
      checks++;
      if ({bus.gnt, bus.mask_out, bus.mask_valid} !== exp_v) begin
        errors++;
        $display("FAIL reuse_out c%0d: got %h expected %h", c, {bus.gnt, bus.mask_out, bus.mask_valid}, exp_v);
      end
      if (c == 7) begin
        checks++;
        if (pulses != 1) begin
          errors++;
          $display("FAIL reuse_pulses_first: got %0d expected 1", pulses);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL reuse_pulses_total: got %0d expected 2", pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_starved();
    test_abort_reset();
`ifdef COMAR_MASK_REUSE_EN
    test_reuse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end
endmodule
